imem_responder: RTL

- Instruction-memory slave answering fetch requests from the core's PC/fetch side.
- Accepts one word-aligned fetch address per request over a valid/ready request channel.
- Returns the 32-bit instruction after a fixed, parameterised latency over a valid/ready response channel.
- A side program-load port fills the word array before or while the core runs; used by the NPC simulation top in place of a combinational inst lookup.

---
 rtl/imem_responder_pkg.sv | 26 ++
 rtl/imem_array.sv | 31 +++
 rtl/imem_responder.sv | 105 ++++++++++
 3 files changed

// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder slice.
// Holds the FSM state encoding, the word-width alias and the fetch range check.
package imem_responder_pkg;

    localparam int REG_BUS_W = 32;
    typedef logic [REG_BUS_W-1:0] reg_bus_t;

    localparam reg_bus_t IMEM_BASE_ADDR = 32'h8000_0000;
    localparam reg_bus_t ERR_INST       = 32'h0000_0000;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_WAIT = 2'd1,
        IMEM_RESP = 2'd2
    } imem_state_e;

    // base_off is (addr - base) modulo 2^32, so addresses below base wrap large and fail.
    function automatic logic imem_addr_err(input logic [1:0] addr_lsb,
                                           input reg_bus_t base_off,
                                           input int unsigned depth);
        logic [32:0] lim;
        lim = 33'(depth) << 2;
        return (addr_lsb != 2'b00) || ({1'b0, base_off} >= lim);
    endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 instruction storage: one write port, one registered read port.
// A read and a write to the same word on one edge return the old word.
module imem_array
    import imem_responder_pkg::*;
#(
    parameter int DEPTH = 4096
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  reg_bus_t                 wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output reg_bus_t                 rdata
);

    reg_bus_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory slave: accepts one fetch at a time and answers after a
// fixed LATENCY with the word sampled at acceptance, or an error response.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int       DEPTH     = 4096,
    parameter int       LATENCY   = 2,
    parameter reg_bus_t BASE_ADDR = IMEM_BASE_ADDR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  reg_bus_t                 req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output reg_bus_t                 resp_inst,
    output logic                     resp_err,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  reg_bus_t                 prog_data
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    imem_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             err_p0;
    reg_bus_t         base_off_p0;
    logic [AW-1:0]    rd_idx_p0;
    reg_bus_t         inst_p1;
    logic             inst_ok_p1;

    assign accept      = req_valid && req_ready;
    assign base_off_p0 = req_addr - BASE_ADDR;
    assign err_p0      = imem_addr_err(req_addr[1:0], base_off_p0, DEPTH);
    assign rd_idx_p0   = base_off_p0[AW+1:2];

    // ---- acceptance edge: word sampled into the array's read register ----
    imem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (accept && !err_p0),
        .raddr (rd_idx_p0),
        .rdata (inst_p1)
    );

    // The read register is never reset; the qualifier forces zero after reset and on errors.
    assign resp_inst = inst_ok_p1 ? inst_p1 : ERR_INST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IMEM_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            inst_ok_p1 <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IMEM_IDLE: begin
                    if (accept) begin
                        resp_err   <= err_p0;
                        inst_ok_p1 <= !err_p0;
                        req_ready  <= 1'b0;
                        if (LATENCY == 1) begin
                            state      <= IMEM_RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= IMEM_WAIT;
                            cnt   <= CNT_W'(LATENCY >= 2 ? LATENCY - 2 : 0);
                        end
                    end
                end
                IMEM_WAIT: begin
                    if (cnt == '0) begin
                        state      <= IMEM_RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                IMEM_RESP: begin
                    if (resp_ready) begin
                        state      <= IMEM_IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IMEM_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
